// File: rtl/bp_sched.sv
// bp_sched: owns the predictor counter-table port (init sweep, fetch reads, FIFO-buffered RMW updates)
module bp_sched #(
  parameter int TAG_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_fetcher_valid,
  input  logic [TAG_W-1:0] in_fetcher_tag,
  output logic             out_fetcher_ready,
  output logic             out_fetcher_valid,
  output logic             out_fetcher_jump,
  input  logic             in_rob_bp,
  input  logic             in_rob_jump,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             out_rob_full,
  output logic             out_init_done,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [TAG_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;
  state_t state, nxt;
  logic [TAG_W-1:0] sweep;
  logic [TAG_W-1:0] q_tag [FIFO_DEPTH];
  logic             q_jump [FIFO_DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      count;
  logic             push, pop, grant, pending;
  logic [TAG_W-1:0] h_tag;
  logic             h_jump;
  assign h_tag = q_tag[rp];
  assign h_jump = q_jump[rp];
  assign pending = count != '0;
  assign out_rob_full = count == (PW+1)'(FIFO_DEPTH);
  assign out_init_done = state != INIT;
  assign push = rdy && in_rob_bp && !out_rob_full;
  assign pop = rdy && state == UPD_WR;
  assign grant = !rst && rdy && state == IDLE && in_fetcher_valid && !out_rob_full;
  assign out_fetcher_ready = grant;
  assign out_fetcher_jump = out_fetcher_valid & tbl_rdata[1];
  always_comb begin
    nxt = state;
    tbl_en = 1'b0;
    tbl_we = 1'b0;
    tbl_addr = h_tag;
    tbl_wdata = h_jump ? (tbl_rdata == 2'b11 ? 2'b11 : tbl_rdata + 2'd1)
                       : (tbl_rdata == 2'b00 ? 2'b00 : tbl_rdata - 2'd1);
    if (!rst && rdy)
      case (state)
        INIT: begin
          tbl_en = 1'b1;
          tbl_we = 1'b1;
          tbl_addr = sweep;
          tbl_wdata = INIT_VAL;
          nxt = &sweep ? IDLE : INIT;
        end
        IDLE: begin
          tbl_en = grant || pending;
          tbl_addr = grant ? in_fetcher_tag : h_tag;
          nxt = (!grant && pending) ? UPD_WR : IDLE;
        end
        UPD_WR: begin
          tbl_en = 1'b1;
          tbl_we = 1'b1;
          nxt = IDLE;
        end
        default: nxt = INIT;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      sweep <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      out_fetcher_valid <= 1'b0;
    end else if (rdy) begin
      state <= nxt;
      out_fetcher_valid <= grant;
      if (state == INIT) sweep <= sweep + TAG_W'(1);
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (!rst && push) begin
      q_tag[wp] <= in_rob_tag;
      q_jump[wp] <= in_rob_jump;
    end
endmodule

// File: doc/bp_sched.md
# bp_sched

Scheduler that owns the single port of the branch predictor's counter table, which is a synchronous single-port RAM of 2-bit saturating counters. It initialises the table after reset with a one-entry-per-cycle sweep. It arbitrates fetcher prediction reads against ROB-committed branch-outcome updates, buffering the updates in a small FIFO. Each update is applied as a two-cycle read-modify-write.

## Interface
- TAG_W, 8, table index width; table holds 2^TAG_W entries
- FIFO_DEPTH, 4, update FIFO entries (power of two, ≥2)
- INIT_VAL, 2'b01, counter value written by the init sweep

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- in_fetcher_valid  in  1  fetcher requests a prediction
- in_fetcher_tag  in  TAG_W  index to predict
- out_fetcher_ready  out  1  request granted this cycle (comb)
- out_fetcher_valid  out  1  prediction valid (cycle after grant)
- out_fetcher_jump  out  1  predicted taken
- in_rob_bp  in  1  committed B-type outcome present
- in_rob_jump  in  1  outcome taken
- in_rob_tag  in  TAG_W  index of that branch
- out_rob_full  out  1  FIFO full; ROB must not assert in_rob_bp
- out_init_done  out  1  init sweep finished
- tbl_en / tbl_we  out  1 / 1  table port enable / write
- tbl_addr  out  TAG_W  table address
- tbl_wdata  out  2  write data
- tbl_rdata  in  2  read data, valid one cycle after the read

## Operation
- States: INIT, IDLE, UPD_WR.
- INIT: tbl_en=1, tbl_we=1, tbl_addr=sweep counter, tbl_wdata=INIT_VAL. The counter increments each cycle. After writing address 2^TAG_W-1, go to IDLE and set out_init_done=1. Fetch is never granted in INIT, but the FIFO still accepts updates.
- IDLE, arbitration:
  - Fetch is granted if in_fetcher_valid && !out_rob_full: out_fetcher_ready=1 and a read at in_fetcher_tag is issued.
  - Otherwise, if the FIFO is non-empty, a read at the head tag is issued and the next state is UPD_WR.
  - Otherwise the port is idle (tbl_en=0).
- A full FIFO therefore preempts the fetcher until one update completes.
- UPD_WR: tbl_we=1, tbl_addr=head tag, tbl_wdata=sat(tbl_rdata, head jump). The FIFO pops, then the state returns to IDLE. Fetch is not granted in this state.
- Saturating arithmetic: taken gives min(v+1, 3); not taken gives max(v-1, 0). The computation is 2-bit only, with no wrap (3 stays 3, 0 stays 0).
- Enqueue happens when rdy && in_rob_bp && !out_rob_full. Push and pop in the same cycle are both honoured, and the count is unchanged.
- out_rob_full = (count == FIFO_DEPTH), combinational from the registered count.
- Responses: out_fetcher_valid is a register set on a grant. out_fetcher_jump = out_fetcher_valid & tbl_rdata[1], and is 0 otherwise.
- rdy=0: no state, FIFO, or sweep change. tbl_en=0 and out_fetcher_ready=0. out_fetcher_valid holds.
- rst (any state, mid-sweep or mid-RMW): the FIFO is emptied (the pending update is lost) and the state returns to INIT with sweep counter 0. While rst is high, tbl_en=0.

## Timing
- Reset values: out_fetcher_ready=0, out_fetcher_valid=0, out_fetcher_jump=0, out_rob_full=0, out_init_done=0, tbl_en=0.
- Init sweep: the first write is in the first cycle after rst falls. Cycle k writes address k. out_init_done rises in cycle 2^TAG_W.
- Fetch latency: grant in cycle n, out_fetcher_valid and jump in cycle n+1. Back-to-back grants give one prediction per cycle.
- Update: read in cycle n, write in cycle n+1. Sustained throughput is one update per 2 cycles.
- An update enqueued in cycle n can issue its read in cycle n+1 at the earliest.
- Read-after-update to the same tag: a fetch granted in the cycle after UPD_WR sees the new value. No bypass is needed because the fetcher is blocked during UPD_WR.

## Test plan
- Reset, TAG_W=4: 16 writes of 01 at addresses 0..15 in consecutive cycles. out_init_done=1 in cycle 16. out_fetcher_ready=0 throughout.
- After init, update tag 3 taken ×3, then fetch tag 3 -> table sequence 01→10→11→11, each update taking 2 cycles. The fetch returns jump=1 one cycle after its grant.
- Tag 5 not taken ×2 -> 01→00→00 (saturates). A following fetch returns jump=0.
- Fetcher asserting valid every cycle while the ROB pushes 4 updates, FIFO_DEPTH=4 -> out_rob_full=1, out_fetcher_ready drops to 0 for the RMW, and fetch resumes after UPD_WR.
- rdy=0 for 3 cycles mid-sweep and mid-RMW -> the sweep address and state hold. Resuming completes with no skipped or duplicated address.
- rst asserted in UPD_WR with 2 FIFO entries -> next cycle: state INIT, count 0, out_rob_full=0, out_fetcher_valid=0, and the sweep restarts at address 0.
